// File: rtl/reg_bank_pkg.sv
// Shared definitions for the 16x16 register bank (write side and read mux).
//   REG_W     : bits per register
//   REG_N     : number of registers
//   SEL_W     : register index width
//   RESET_VAL : value every register takes on reset
//   state_e   : clear-sweep FSM states
package reg_bank_pkg;

  localparam int REG_W = 16;
  localparam int REG_N = 16;
  localparam int SEL_W = 4;

  localparam logic [REG_W-1:0] RESET_VAL = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/clear_sequencer.sv
// Bulk-clear sequencer for the register bank.
// Owns the IDLE/CLEAR FSM, the sweep index counter, the latched clear value
// and the BUSY/DONE status. Each CLEAR cycle it strobes one register index.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clr_req_i    : start sweep (sampled in IDLE only)
//   clr_val_i    : value to sweep into the bank, latched at sweep start
//   busy_o       : sweep in progress
//   done_o       : one-cycle pulse after the last register is written
//   wr_rdy_o     : write port may accept (FSM idle)
//   clr_stb_o    : write clr_val_o into register clr_idx_o this cycle
//   clr_idx_o    : current sweep index
//   clr_val_o    : latched sweep value
module clear_sequencer
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = reg_bank_pkg::REG_W,
  parameter int SEL_W = reg_bank_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req_i,
  input  logic [WIDTH-1:0] clr_val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             wr_rdy_o,
  output logic             clr_stb_o,
  output logic [SEL_W-1:0] clr_idx_o,
  output logic [WIDTH-1:0] clr_val_o
);

  localparam logic [SEL_W-1:0] LAST_IDX = {SEL_W{1'b1}};

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          idx_d   = '0;
          val_d   = clr_val_i;
        end
      end
      CLEAR: begin
        // The counter wraps naturally from LAST_IDX back to 0 on exit.
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == CLEAR);
  assign wr_rdy_o  = (state_q == IDLE);
  assign clr_stb_o = (state_q == CLEAR);
  assign clr_idx_o = idx_q;
  assign clr_val_o = val_q;
  assign done_o    = done_q;

endmodule

// File: rtl/reg_bank_writer_16x16.sv
// Write side of the 16x16 register bank.
// Holds DEPTH registers of WIDTH bits, accepts byte-masked single-register
// writes through a ready/valid port and runs a bulk clear sweep on request.
// All registers are exposed flat on REGS for the read multiplexer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   WR_EN      : write request (valid)
//   WR_SEL     : target register index
//   WR_DATA    : write data
//   WR_MASK    : byte enables, bit b covers bits [8b+7:8b]
//   WR_RDY     : write port ready (low while sweeping)
//   CLR_REQ    : start clear sweep
//   CLR_VAL    : value written by the sweep
//   BUSY       : sweep in progress
//   DONE       : one-cycle pulse after sweep completes
//   DIRTY      : per-register written-since-clear flags
//   REGS       : flat register bank, register n at REGS[WIDTH*n +: WIDTH]
module reg_bank_writer_16x16
  import reg_bank_pkg::*;
#(
  parameter int                     WIDTH     = reg_bank_pkg::REG_W,
  parameter int                     DEPTH     = reg_bank_pkg::REG_N,
  parameter int                     SEL_W     = reg_bank_pkg::SEL_W,
  parameter logic [WIDTH-1:0]       RESET_VAL = reg_bank_pkg::RESET_VAL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WR_EN,
  input  logic [SEL_W-1:0]       WR_SEL,
  input  logic [WIDTH-1:0]       WR_DATA,
  input  logic [WIDTH/8-1:0]     WR_MASK,
  output logic                   WR_RDY,
  input  logic                   CLR_REQ,
  input  logic [WIDTH-1:0]       CLR_VAL,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [DEPTH-1:0]       DIRTY,
  output logic [WIDTH*DEPTH-1:0] REGS
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;

  logic             wr_rdy;
  logic             clr_stb;
  logic [SEL_W-1:0] clr_idx;
  logic [WIDTH-1:0] clr_val;
  logic             wr_acc;

  function automatic logic [WIDTH-1:0] byte_merge(
    input logic [WIDTH-1:0]  old_v,
    input logic [WIDTH-1:0]  new_v,
    input logic [NBYTES-1:0] mask
  );
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < NBYTES; b++) begin
      if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  clear_sequencer #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_req_i (CLR_REQ),
    .clr_val_i (CLR_VAL),
    .busy_o    (BUSY),
    .done_o    (DONE),
    .wr_rdy_o  (wr_rdy),
    .clr_stb_o (clr_stb),
    .clr_idx_o (clr_idx),
    .clr_val_o (clr_val)
  );

  assign WR_RDY = wr_rdy;
  assign wr_acc = WR_EN && wr_rdy;

  // Writes are only accepted in IDLE and the sweep only strobes in CLEAR,
  // so the two update sources never target the bank in the same cycle.
  // A write accepted on the edge that starts a sweep still commits; the sweep
  // overwrites that register when its index comes round.
  always_comb begin
    regs_d  = regs_q;
    dirty_d = dirty_q;
    if (wr_acc) begin
      regs_d[WR_SEL]  = byte_merge(regs_q[WR_SEL], WR_DATA, WR_MASK);
      dirty_d[WR_SEL] = 1'b1;
    end
    if (clr_stb) begin
      regs_d[clr_idx]  = clr_val;
      dirty_d[clr_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) regs_q[n] <= RESET_VAL;
      dirty_q <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) regs_q[n] <= regs_d[n];
      dirty_q <= dirty_d;
    end
  end

  for (genvar n = 0; n < DEPTH; n++) begin : g_flat
    assign REGS[WIDTH*n +: WIDTH] = regs_q[n];
  end

  assign DIRTY = dirty_q;

endmodule

// File: tb/tb_reg_bank_writer_16x16.sv
module tb_reg_bank_writer_16x16;

  logic         clk = 1'b0;
  logic         rst;
  logic         WR_EN;
  logic [3:0]   WR_SEL;
  logic [15:0]  WR_DATA;
  logic [1:0]   WR_MASK;
  logic         WR_RDY;
  logic         CLR_REQ;
  logic [15:0]  CLR_VAL;
  logic         BUSY;
  logic         DONE;
  logic [15:0]  DIRTY;
  logic [255:0] REGS;

  always #5 clk = ~clk;

  reg_bank_writer_16x16 dut (
    .clk     (clk),
    .rst     (rst),
    .WR_EN   (WR_EN),
    .WR_SEL  (WR_SEL),
    .WR_DATA (WR_DATA),
    .WR_MASK (WR_MASK),
    .WR_RDY  (WR_RDY),
    .CLR_REQ (CLR_REQ),
    .CLR_VAL (CLR_VAL),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .DIRTY   (DIRTY),
    .REGS    (REGS)
  );

  typedef struct packed {
    logic [255:0] regs;
    logic [15:0]  dirty;
    logic         busy;
    logic         done;
    logic         rdy;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the bank
  logic [15:0] m_regs [16];
  logic [15:0] m_dirty;
  logic        m_busy;
  logic [3:0]  m_idx;
  logic [15:0] m_val;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] r;
    for (int n = 0; n < 16; n++) r[16*n +: 16] = m_regs[n];
    return r;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 16; n++) m_regs[n] = 16'h0000;
    m_dirty = '0;
    m_busy  = 1'b0;
    m_idx   = '0;
    m_val   = '0;
  endtask

  function automatic logic [15:0] reg_of(input int n);
    return REGS[16*n +: 16];
  endfunction

  // Advance one clock: push the model's expectation for this edge, then pop
  // and compare once the DUT has clocked. Inputs change only at negedge.
  task automatic step(input string tag);
    exp_t e;
    logic done_n;
    done_n = 1'b0;
    if (!m_busy) begin
      if (WR_EN) begin
        for (int b = 0; b < 2; b++)
          if (WR_MASK[b]) m_regs[WR_SEL][8*b +: 8] = WR_DATA[8*b +: 8];
        m_dirty[WR_SEL] = 1'b1;
      end
      if (CLR_REQ) begin
        m_busy = 1'b1;
        m_idx  = 4'd0;
        m_val  = CLR_VAL;
      end
    end else begin
      m_regs[m_idx]  = m_val;
      m_dirty[m_idx] = 1'b0;
      if (m_idx == 4'd15) begin
        m_busy = 1'b0;
        done_n = 1'b1;
      end
      m_idx = m_idx + 4'd1;
    end
    e.regs  = pack_model();
    e.dirty = m_dirty;
    e.busy  = m_busy;
    e.done  = done_n;
    e.rdy   = !m_busy;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 256'd1, 256'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".regs"},  REGS,   e.regs);
      check_eq({tag, ".dirty"}, DIRTY,  e.dirty);
      check_eq({tag, ".busy"},  BUSY,   e.busy);
      check_eq({tag, ".done"},  DONE,   e.done);
      check_eq({tag, ".rdy"},   WR_RDY, e.rdy);
    end
    @(negedge clk);
  endtask

  // Assert reset between edges and check that outputs clear immediately.
  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_eq({tag, ".regs"},  REGS,   256'd0);
    check_eq({tag, ".dirty"}, DIRTY,  256'd0);
    check_eq({tag, ".busy"},  BUSY,   256'd0);
    check_eq({tag, ".done"},  DONE,   256'd0);
    check_eq({tag, ".rdy"},   WR_RDY, 256'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst     = 1'b1;
    WR_EN   = 1'b0;
    WR_SEL  = '0;
    WR_DATA = '0;
    WR_MASK = '0;
    CLR_REQ = 1'b0;
    CLR_VAL = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("por.regs",  REGS,   256'd0);
    check_eq("por.dirty", DIRTY,  256'd0);
    check_eq("por.busy",  BUSY,   256'd0);
    check_eq("por.rdy",   WR_RDY, 256'd1);
    @(negedge clk);

    // Full write then low-byte-only write to register 5
    WR_EN = 1'b1; WR_SEL = 4'd5; WR_DATA = 16'hA55A; WR_MASK = 2'b11;
    step("wr_full");
    check_eq("wr_full.reg5",  reg_of(5), 16'hA55A);
    check_eq("wr_full.dirty", DIRTY,     16'h0020);
    WR_DATA = 16'h1234; WR_MASK = 2'b01;
    step("wr_mask");
    check_eq("wr_mask.reg5", reg_of(5), 16'hA534);
    // Zero mask still marks the register dirty
    WR_SEL = 4'd9; WR_DATA = 16'hFFFF; WR_MASK = 2'b00;
    step("wr_mask0");
    check_eq("wr_mask0.reg9",  reg_of(9), 16'h0000);
    check_eq("wr_mask0.dirty", DIRTY,     16'h0220);
    WR_EN = 1'b0;

    async_reset_check("rst_mid");

    // Fill every register with its own index, then sweep with FFFF
    WR_EN = 1'b1; WR_MASK = 2'b11;
    for (int n = 0; n < 16; n++) begin
      WR_SEL = 4'(n); WR_DATA = 16'(n);
      step("fill");
    end
    WR_EN = 1'b0;
    CLR_VAL = 16'hFFFF; CLR_REQ = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    step("sweep_start");
    CLR_REQ = 1'b0; CLR_VAL = 16'h0000;
    for (int c = 0; c < 18; c++) begin
      if (BUSY) busy_cnt++;
      step("sweep");
      if (DONE) done_cnt++;
    end
    check_eq("sweep.busy_cycles", 256'(busy_cnt), 256'd16);
    check_eq("sweep.done_pulses", 256'(done_cnt), 256'd1);
    check_eq("sweep.dirty",       DIRTY,          256'd0);
    check_eq("sweep.regs",        REGS,           {16{16'hFFFF}});

    // Write held across a sweep is ignored until the FSM returns to IDLE
    CLR_VAL = 16'hFFFF; CLR_REQ = 1'b1;
    step("hold_start");
    CLR_REQ = 1'b0;
    WR_EN = 1'b1; WR_SEL = 4'd3; WR_DATA = 16'h1357; WR_MASK = 2'b11;
    for (int c = 0; c < 16; c++) step("hold_sweep");
    check_eq("hold.reg3_before", reg_of(3), 16'hFFFF);
    step("hold_land");
    check_eq("hold.reg3_after", reg_of(3), 16'h1357);
    WR_EN = 1'b0;

    // Simultaneous write and clear request
    WR_EN = 1'b1; WR_SEL = 4'd0; WR_DATA = 16'h00AA; WR_MASK = 2'b11;
    CLR_REQ = 1'b1; CLR_VAL = 16'h0000;
    step("simul");
    check_eq("simul.reg0_wr", reg_of(0), 16'h00AA);
    WR_EN = 1'b0; CLR_REQ = 1'b0;
    step("simul_sweep");
    check_eq("simul.reg0_clr", reg_of(0), 16'h0000);
    for (int c = 0; c < 15; c++) step("simul_sweep");
    check_eq("simul.done",   DONE,     256'd1);
    check_eq("simul.dirty0", DIRTY[0], 256'd0);
    step("simul_idle");

    // Reset part-way through a sweep, then confirm the index restarts at 0
    CLR_VAL = 16'hABCD; CLR_REQ = 1'b1;
    step("abort_start");
    CLR_REQ = 1'b0;
    for (int c = 0; c < 7; c++) step("abort_sweep");
    async_reset_check("rst_sweep");
    #1;
    check_eq("rst_sweep.no_done", DONE, 256'd0);
    CLR_VAL = 16'h5A5A; CLR_REQ = 1'b1;
    step("restart");
    CLR_REQ = 1'b0;
    step("restart_sweep");
    check_eq("restart.reg0", reg_of(0), 16'h5A5A);
    check_eq("restart.reg1", reg_of(1), 16'h0000);
    for (int c = 0; c < 16; c++) step("restart_sweep");

    // Random writes with occasional sweeps
    for (int c = 0; c < 60; c++) begin
      WR_EN   = 1'($urandom_range(0, 3) != 0);
      WR_SEL  = 4'($urandom_range(0, 15));
      WR_DATA = 16'($urandom);
      WR_MASK = 2'($urandom_range(0, 3));
      CLR_REQ = 1'($urandom_range(0, 19) == 0);
      CLR_VAL = 16'($urandom);
      step("rand");
    end
    WR_EN = 1'b0; CLR_REQ = 1'b0;
    for (int c = 0; c < 18; c++) step("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
